hilo_unit: RTL and testbench

Holds the architectural HI/LO register pair for the interrupt-capable pipelined CPU and consumes the 64-bit `{hi, lo}` result that the execute-stage ALU produces for MULT/MULTU/DIV/DIVU. Write requests are carried through internal MEM and WB stage registers and committed in WB, so an interrupt flush can discard writes that are still speculative. MFHI/MFLO reads get a fully forwarded value, and no stall is ever needed for HI/LO hazards.

---
 rtl/hilo_unit.sv | 83 ++++++++
 tb/tb_hilo_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO register pair with MEM/WB write pipeline; commit in WB (3 cycles EX->arch), reads forwarded combinationally.
// Stall freezes MEM/WB without committing; flush kills EX/MEM entries but lets the WB entry commit.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [1:0]         ex_we_i,
  input  logic               ex_mthi_i,
  input  logic [2*WIDTH-1:0] ex_res_i,
  input  logic               rd_sel_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               commit_o
);

  logic [1:0]       r_mem_we, r_wb_we;
  logic [WIDTH-1:0] r_mem_hi, r_mem_lo, r_wb_hi, r_wb_lo;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_commit;

  logic [WIDTH-1:0] w_ex_hi, w_ex_lo;
  logic             w_advance, w_commit_en;
  logic [WIDTH-1:0] w_fwd_hi, w_fwd_lo;

  assign w_ex_hi     = ex_mthi_i ? ex_res_i[WIDTH-1:0] : ex_res_i[2*WIDTH-1:WIDTH];
  assign w_ex_lo     = ex_res_i[WIDTH-1:0];
  assign w_advance   = !stall && !flush;
  // The WB entry is past the precise-exception point, so a flush still retires it.
  assign w_commit_en = !stall || flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we <= '0;
      r_mem_hi <= '0;
      r_mem_lo <= '0;
      r_wb_we  <= '0;
      r_wb_hi  <= '0;
      r_wb_lo  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_commit <= 1'b0;
    end else begin
      if (flush) begin
        r_mem_we <= '0;
        r_wb_we  <= '0;
      end else if (w_advance) begin
        r_mem_we <= ex_we_i;
        r_mem_hi <= w_ex_hi;
        r_mem_lo <= w_ex_lo;
        r_wb_we  <= r_mem_we;
        r_wb_hi  <= r_mem_hi;
        r_wb_lo  <= r_mem_lo;
      end
      if (w_commit_en) begin
        if (r_wb_we[1]) r_hi <= r_wb_hi;
        if (r_wb_we[0]) r_lo <= r_wb_lo;
      end
      r_commit <= w_commit_en && (|r_wb_we);
    end
  end

  // Youngest in-flight writer wins, independently for each half.
  always_comb begin
    w_fwd_hi = r_hi;
    if (r_wb_we[1])  w_fwd_hi = r_wb_hi;
    if (r_mem_we[1]) w_fwd_hi = r_mem_hi;
    if (ex_we_i[1])  w_fwd_hi = w_ex_hi;
    w_fwd_lo = r_lo;
    if (r_wb_we[0])  w_fwd_lo = r_wb_lo;
    if (r_mem_we[0]) w_fwd_lo = r_mem_lo;
    if (ex_we_i[0])  w_fwd_lo = w_ex_lo;
  end

  assign rd_data_o = rd_sel_i ? w_fwd_hi : w_fwd_lo;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;
  assign commit_o  = r_commit;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: commit scoreboard plus inline forwarding/timing checks.
module tb_hilo_unit;
  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  ex_we_i;
  logic        ex_mthi_i;
  logic [63:0] ex_res_i;
  logic        rd_sel_i;
  logic [31:0] rd_data_o, hi_o, lo_o;
  logic        commit_o;

  int checks = 0;
  int errors = 0;
  int commit_cnt = 0;
  logic [63:0] sb[$];
  logic [31:0] mdl_hi = 32'h0;
  logic [31:0] mdl_lo = 32'h0;

  hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_we_i(ex_we_i), .ex_mthi_i(ex_mthi_i), .ex_res_i(ex_res_i),
    .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o),
    .hi_o(hi_o), .lo_o(lo_o), .commit_o(commit_o)
  );

  always #5 clk = ~clk;

  // Each commit pulse retires the oldest expected architectural state.
  always @(negedge clk) begin
    if (rst === 1'b0 && commit_o === 1'b1) begin
      logic [63:0] exp_v;
      commit_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got hi=%h lo=%h, no commit expected", hi_o, lo_o);
      end else begin
        exp_v = sb.pop_front();
        if ({hi_o, lo_o} !== exp_v) begin
          errors++;
          $display("FAIL commit_state: got %h expected %h", {hi_o, lo_o}, exp_v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_we_i = 2'b00; ex_mthi_i = 1'b0; ex_res_i = 64'h0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [1:0] we, input logic mthi, input logic [63:0] res, input bit killed);
    ex_we_i = we; ex_mthi_i = mthi; ex_res_i = res;
    if (!killed && we != 2'b00) begin
      if (we[1]) mdl_hi = mthi ? res[31:0] : res[63:32];
      if (we[0]) mdl_lo = res[31:0];
      sb.push_back({mdl_hi, mdl_lo});
    end
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending commits, expected 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); rd_sel_i = 1'b1;
    tick();
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi_o); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo_o); end
    checks++; if (commit_o !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", commit_o); end
    checks++; if (rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_hi: got %h expected 0", rd_data_o); end
    rd_sel_i = 1'b0; #1;
    checks++; if (rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_lo: got %h expected 0", rd_data_o); end
    rst = 1'b0;
  endtask

  task automatic test_mult();
    tick();
    rd_sel_i = 1'b1;
    issue(2'b11, 1'b0, 64'h0000_0001_8000_0000, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 4) begin
        checks++;
        if (rd_data_o !== 32'h1) begin errors++; $display("FAIL mult_fwd_c%0d: got %h expected 1", c, rd_data_o); end
      end
      checks++;
      if (commit_o !== (c == 3)) begin errors++; $display("FAIL mult_commit_c%0d: got %b expected %b", c, commit_o, c == 3); end
      if (c == 2 || c == 3) begin
        checks++;
        if ({hi_o, lo_o} !== (c == 3 ? 64'h0000_0001_8000_0000 : 64'h0)) begin
          errors++; $display("FAIL mult_arch_c%0d: got %h", c, {hi_o, lo_o});
        end
      end
      tick();
      idle();
    end
  endtask

  task automatic test_forward();
    issue(2'b11, 1'b0, {32'h5, 32'h7}, 0);
    tick();
    issue(2'b01, 1'b0, {32'h0, 32'h9}, 0);
    rd_sel_i = 1'b0; #1;
    checks++; if (rd_data_o !== 32'h9) begin errors++; $display("FAIL fwd_lo: got %h expected 9", rd_data_o); end
    rd_sel_i = 1'b1; #1;
    checks++; if (rd_data_o !== 32'h5) begin errors++; $display("FAIL fwd_hi: got %h expected 5", rd_data_o); end
    tick();
    drain();
    checks++; if ({hi_o, lo_o} !== {32'h5, 32'h9}) begin errors++; $display("FAIL fwd_final: got %h expected 5/9", {hi_o, lo_o}); end
  endtask

  task automatic test_stall();
    int c0 = commit_cnt;
    issue(2'b11, 1'b0, {32'hA, 32'hB}, 0);
    tick(); idle();
    tick();
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rd_sel_i = 1'b1; #1;
      checks++; if (rd_data_o !== 32'hA) begin errors++; $display("FAIL stall_fwd_%0d: got %h expected a", c, rd_data_o); end
      tick();
      checks++; if ({hi_o, lo_o} !== {32'h5, 32'h9} || commit_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d: got %h commit=%b expected 5/9 commit=0", c, {hi_o, lo_o}, commit_o);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if ({hi_o, lo_o} !== {32'hA, 32'hB} || commit_o !== 1'b1) begin
      errors++; $display("FAIL stall_late_commit: got %h commit=%b expected a/b commit=1", {hi_o, lo_o}, commit_o);
    end
    tick(); tick();
    checks++; if (commit_cnt - c0 !== 1) begin errors++; $display("FAIL stall_commit_count: got %0d expected 1", commit_cnt - c0); end
    drain();
  endtask

  task automatic test_flush();
    int c0 = commit_cnt;
    issue(2'b01, 1'b0, 64'h1, 0);
    tick();
    issue(2'b01, 1'b0, 64'h2, 1);
    tick();
    issue(2'b01, 1'b0, 64'h3, 1);
    flush = 1'b1; rd_sel_i = 1'b0; #1;
    checks++; if (rd_data_o !== 32'h3) begin errors++; $display("FAIL flush_ex_fwd: got %h expected 3", rd_data_o); end
    tick(); idle();
    checks++; if (lo_o !== 32'h1 || commit_o !== 1'b1) begin
      errors++; $display("FAIL flush_wb_commit: got lo=%h commit=%b expected 1/1", lo_o, commit_o);
    end
    for (int c = 0; c < 5; c++) tick();
    checks++; if (lo_o !== 32'h1 || commit_cnt - c0 !== 1) begin
      errors++; $display("FAIL flush_killed: got lo=%h commits=%0d expected lo=1 commits=1", lo_o, commit_cnt - c0);
    end
    drain();
  endtask

  task automatic test_mthi();
    issue(2'b01, 1'b0, {32'h0, 32'h1234}, 0);
    tick();
    issue(2'b10, 1'b1, {32'h5555_5555, 32'hDEAD_BEEF}, 0);
    tick();
    drain();
    checks++; if (hi_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi: got %h expected deadbeef", hi_o); end
    checks++; if (lo_o !== 32'h1234) begin errors++; $display("FAIL mthi_lo: got %h expected 1234", lo_o); end
  endtask

  task automatic test_back_to_back();
    int c0 = commit_cnt;
    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, 0);
      tick();
    end
    drain();
    checks++; if (commit_cnt - c0 !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", commit_cnt - c0); end
    checks++; if ({hi_o, lo_o} !== {mdl_hi, mdl_lo}) begin
      errors++; $display("FAIL b2b_final: got %h expected %h", {hi_o, lo_o}, {mdl_hi, mdl_lo});
    end
  endtask

  task automatic test_reset_mid();
    int c0 = commit_cnt;
    issue(2'b11, 1'b0, {32'h77, 32'h88}, 1);
    tick(); idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_hi = 32'h0; mdl_lo = 32'h0;
    for (int c = 0; c < 5; c++) tick();
    checks++; if ({hi_o, lo_o} !== 64'h0 || commit_cnt != c0) begin
      errors++; $display("FAIL reset_mid: got %h commits=%0d expected 0 commits=0", {hi_o, lo_o}, commit_cnt - c0);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_forward();
    test_stall();
    test_flush();
    test_mthi();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
